// File: rtl/sensor_pattern_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sensor_pattern_pkg
// Brief    : Shared types and constants for the sensor test-pattern generator.
// Revision : 1.0
// ============================================================================
package sensor_pattern_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FRONT  = 3'd1,
    ST_LINE   = 3'd2,
    ST_HBLANK = 3'd3,
    ST_BACK   = 3'd4,
    ST_VBLANK = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    PAT_LINE_INC  = 2'd0,
    PAT_FRAME_INC = 2'd1,
    PAT_PIX_INC   = 2'd2,
    PAT_ZERO      = 2'd3
  } pattern_e;

  // fval-high clocks before the first and after the last lval of a frame
  localparam int unsigned c_fb_len = 3;

endpackage
`default_nettype wire

// File: rtl/pattern_data_gen.sv
`default_nettype none
// ============================================================================
// Module   : pattern_data_gen
// Brief    : Maps pattern select, line, column and frame count to pixel data.
// Revision : 1.0
// ============================================================================
module pattern_data_gen
  import sensor_pattern_pkg::*;
#(
  parameter int DATA_WIDTH  = 10,
  parameter int CHANNEL_NUM = 4
) (
  input  pattern_e                            i_pattern,
  input  logic [DATA_WIDTH-1:0]               i_line,
  input  logic [DATA_WIDTH-1:0]               i_column,
  input  logic [DATA_WIDTH-1:0]               i_frame_cnt,
  output logic [DATA_WIDTH*CHANNEL_NUM-1:0]   o_pix_data
);

  localparam logic [DATA_WIDTH-1:0] c_chan_num = DATA_WIDTH'(CHANNEL_NUM);

  // Only the low DATA_WIDTH bits of column*CHANNEL_NUM+k survive the modulo
  logic [DATA_WIDTH-1:0] w_col_base;
  assign w_col_base = i_column * c_chan_num;

  for (genvar k = 0; k < CHANNEL_NUM; k++) begin : g_chan
    logic [DATA_WIDTH-1:0] w_val;

    always_comb begin
      w_val = '0;
      case (i_pattern)
        PAT_LINE_INC:  w_val = i_line;
        PAT_FRAME_INC: w_val = i_frame_cnt;
        PAT_PIX_INC:   w_val = w_col_base + DATA_WIDTH'(k);
        default:       w_val = '0;
      endcase
    end

    assign o_pix_data[k*DATA_WIDTH +: DATA_WIDTH] = w_val;
  end

endmodule
`default_nettype wire

// File: rtl/sensor_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : sensor_pattern_gen
// Brief    : fval/lval/pixel-data test-pattern source for the sensor stream.
// Revision : 1.0
// ============================================================================
module sensor_pattern_gen
  import sensor_pattern_pkg::*;
#(
  parameter int DATA_WIDTH  = 10,
  parameter int CHANNEL_NUM = 4,
  parameter int REG_WD      = 32
) (
  input  logic                              clk_sensor_pix,
  input  logic                              reset_sensor_n,
  input  logic                              i_clk_en,
  input  logic                              i_enable,
  input  logic [REG_WD-1:0]                 iv_width,
  input  logic [REG_WD-1:0]                 iv_height,
  input  logic [REG_WD-1:0]                 iv_h_blank,
  input  logic [REG_WD-1:0]                 iv_v_blank,
  input  logic [1:0]                        iv_pattern,
  output logic                              o_fval,
  output logic                              o_lval,
  output logic [DATA_WIDTH*CHANNEL_NUM-1:0] ov_pix_data
);

  localparam logic [REG_WD-1:0] c_one     = REG_WD'(1);
  localparam logic [REG_WD-1:0] c_fb_last = REG_WD'(c_fb_len - 1);

  state_e                            r_state, w_state_nxt;
  logic [REG_WD-1:0]                 r_cnt, w_cnt_nxt;
  logic [REG_WD-1:0]                 r_line, w_line_nxt;
  logic [DATA_WIDTH-1:0]             r_frame_cnt, w_frame_nxt;
  logic                              w_latch;
  logic                              w_start;

  logic [REG_WD-1:0]                 r_width;
  logic [REG_WD-1:0]                 r_height;
  logic [REG_WD-1:0]                 r_h_blank;
  logic [REG_WD-1:0]                 r_v_blank;
  pattern_e                          r_pattern;

  logic                              r_fval;
  logic                              r_lval;
  logic [DATA_WIDTH*CHANNEL_NUM-1:0] r_pix;
  logic [DATA_WIDTH*CHANNEL_NUM-1:0] w_pix;

  assign w_start = i_enable && (iv_width != '0) && (iv_height != '0);

  always_ff @(posedge clk_sensor_pix or negedge reset_sensor_n) begin
    if (!reset_sensor_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_line      <= '0;
      r_frame_cnt <= '0;
    end else if (i_clk_en) begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_line      <= w_line_nxt;
      r_frame_cnt <= w_frame_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_line_nxt  = r_line;
    w_frame_nxt = r_frame_cnt;
    w_latch     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_FRONT;
          w_cnt_nxt   = '0;
          w_latch     = 1'b1;
        end
      end
      ST_FRONT: begin
        if (r_cnt == c_fb_last) begin
          w_state_nxt = ST_LINE;
          w_cnt_nxt   = '0;
          w_line_nxt  = '0;
        end else begin
          w_cnt_nxt = r_cnt + c_one;
        end
      end
      ST_LINE: begin
        if (r_cnt == r_width - c_one) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (r_line == r_height - c_one) ? ST_BACK : ST_HBLANK;
        end else begin
          w_cnt_nxt = r_cnt + c_one;
        end
      end
      ST_HBLANK: begin
        if (r_cnt == r_h_blank - c_one) begin
          w_state_nxt = ST_LINE;
          w_cnt_nxt   = '0;
          w_line_nxt  = r_line + c_one;
        end else begin
          w_cnt_nxt = r_cnt + c_one;
        end
      end
      ST_BACK: begin
        if (r_cnt == c_fb_last) begin
          w_state_nxt = ST_VBLANK;
          w_cnt_nxt   = '0;
          w_frame_nxt = r_frame_cnt + DATA_WIDTH'(1);
        end else begin
          w_cnt_nxt = r_cnt + c_one;
        end
      end
      ST_VBLANK: begin
        if (r_cnt == r_v_blank - c_one) begin
          w_cnt_nxt = '0;
          // i_enable is only sampled here, so a dropped enable finishes the frame
          if (w_start) begin
            w_state_nxt = ST_FRONT;
            w_latch     = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + c_one;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Frame geometry is frozen per frame; zero blanking is stretched to one clock
  always_ff @(posedge clk_sensor_pix or negedge reset_sensor_n) begin
    if (!reset_sensor_n) begin
      r_width   <= '0;
      r_height  <= '0;
      r_h_blank <= c_one;
      r_v_blank <= c_one;
      r_pattern <= PAT_LINE_INC;
    end else if (i_clk_en && w_latch) begin
      r_width   <= iv_width;
      r_height  <= iv_height;
      r_h_blank <= (iv_h_blank == '0) ? c_one : iv_h_blank;
      r_v_blank <= (iv_v_blank == '0) ? c_one : iv_v_blank;
      r_pattern <= pattern_e'(iv_pattern);
    end
  end

  pattern_data_gen #(
    .DATA_WIDTH  (DATA_WIDTH),
    .CHANNEL_NUM (CHANNEL_NUM)
  ) u_pattern_data_gen (
    .i_pattern   (r_pattern),
    .i_line      (r_line[DATA_WIDTH-1:0]),
    .i_column    (r_cnt[DATA_WIDTH-1:0]),
    .i_frame_cnt (r_frame_cnt),
    .o_pix_data  (w_pix)
  );

  // Outputs trail the state register by one clk_en cycle, keeping all three aligned
  always_ff @(posedge clk_sensor_pix or negedge reset_sensor_n) begin
    if (!reset_sensor_n) begin
      r_fval <= 1'b0;
      r_lval <= 1'b0;
      r_pix  <= '0;
    end else if (i_clk_en) begin
      r_fval <= (r_state != ST_IDLE) && (r_state != ST_VBLANK);
      r_lval <= (r_state == ST_LINE);
      r_pix  <= (r_state == ST_LINE) ? w_pix : '0;
    end
  end

  assign o_fval      = r_fval;
  assign o_lval      = r_lval;
  assign ov_pix_data = r_pix;

endmodule
`default_nettype wire

// File: tb/tb_sensor_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_sensor_pattern_gen
// Brief    : Directed self-checking bench for sensor_pattern_gen.
// Revision : 1.0
// ============================================================================
module tb_sensor_pattern_gen;

  localparam int DW = 10;
  localparam int CN = 4;
  localparam int RW = 32;
  localparam int PW = DW * CN;

  localparam logic [PW-1:0] PIX_COL0 = {10'd3, 10'd2, 10'd1, 10'd0};
  localparam logic [PW-1:0] PIX_COL3 = {10'd15, 10'd14, 10'd13, 10'd12};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  bit            clk_en = 1'b1;
  bit            toggle_en = 1'b0;
  logic          enable = 1'b0;
  logic [RW-1:0] width = '0;
  logic [RW-1:0] height = '0;
  logic [RW-1:0] h_blank = '0;
  logic [RW-1:0] v_blank = '0;
  logic [1:0]    pattern = '0;
  logic          fval;
  logic          lval;
  logic [PW-1:0] pix;

  int checks = 0;
  int errors = 0;

  logic [PW-1:0] line_first [0:63];
  bit            line_const [0:63];
  logic [PW-1:0] col_data   [0:63];

  always #5 clk = ~clk;
  always @(negedge clk) clk_en = toggle_en ? ~clk_en : 1'b1;

  sensor_pattern_gen #(
    .DATA_WIDTH  (DW),
    .CHANNEL_NUM (CN),
    .REG_WD      (RW)
  ) dut (
    .clk_sensor_pix (clk),
    .reset_sensor_n (rst_n),
    .i_clk_en       (clk_en),
    .i_enable       (enable),
    .iv_width       (width),
    .iv_height      (height),
    .iv_h_blank     (h_blank),
    .iv_v_blank     (v_blank),
    .iv_pattern     (pattern),
    .o_fval         (fval),
    .o_lval         (lval),
    .ov_pix_data    (pix)
  );

  function automatic logic [PW-1:0] rep(input int v);
    logic [DW-1:0] t;
    t = v[DW-1:0];
    return {CN{t}};
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic cfg(input int w, input int h, input int hb, input int vb, input int pat);
    width   = RW'(w);
    height  = RW'(h);
    h_blank = RW'(hb);
    v_blank = RW'(vb);
    pattern = 2'(pat);
  endtask

  // Waits for fval to rise, then profiles one frame up to the first fval-low sample
  task automatic measure_frame(input int bound, output bit ok, output int fhi, output int nl,
                               output int lmin, output int lmax, output int front,
                               output int back, output int zv);
    int t, cur;
    bit p;
    ok = 1'b0; fhi = 0; nl = 0; lmin = 1 << 30; lmax = 0;
    front = -1; back = 0; zv = 0; t = 0; cur = 0; p = 1'b0;
    while (fval !== 1'b1 && t < bound) begin @(negedge clk); t++; end
    if (fval !== 1'b1) return;
    while (fval === 1'b1 && t < bound) begin
      if (lval === 1'b1) begin
        if (!p) begin
          cur = 0;
          if (nl == 0) front = fhi;
          if (nl < 64) begin line_first[nl] = pix; line_const[nl] = 1'b1; end
        end
        if (nl < 64 && pix !== line_first[nl]) line_const[nl] = 1'b0;
        if (nl == 0 && cur < 64) col_data[cur] = pix;
        cur++;
      end else begin
        if (p) begin
          nl++;
          if (cur < lmin) lmin = cur;
          if (cur > lmax) lmax = cur;
          back = 0;
        end
        back++;
        if (pix !== '0) zv++;
      end
      p = (lval === 1'b1);
      fhi++;
      @(negedge clk);
      t++;
    end
    ok = (fval === 1'b0);
  endtask

  task automatic measure_low(input int bound, output int n);
    n = 0;
    while (fval !== 1'b1 && n < bound) begin n++; @(negedge clk); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (fval !== 1'b0) begin errors++; $display("FAIL reset_fval: got %b expected 0", fval); end
    checks++; if (lval !== 1'b0) begin errors++; $display("FAIL reset_lval: got %b expected 0", lval); end
    checks++; if (pix !== '0) begin errors++; $display("FAIL reset_pix: got %h expected 0", pix); end
    rst_n = 1'b1;
    cfg(16, 16, 4, 10, 0);
    repeat (6) @(negedge clk);
    checks++; if (fval !== 1'b0) begin errors++; $display("FAIL idle_no_enable_fval: got %b expected 0", fval); end
  endtask

  task automatic test_line_inc();
    bit ok; int fhi, nl, lmin, lmax, front, back, zv, low, bad;
    apply_reset();
    cfg(16, 16, 4, 10, 0);
    enable = 1'b1;
    for (int fr = 0; fr < 2; fr++) begin
      measure_frame(2000, ok, fhi, nl, lmin, lmax, front, back, zv);
      checks++; if (!ok || fhi != 322) begin errors++; $display("FAIL line_fval_high f%0d: got %0d expected 322", fr, fhi); end
      checks++; if (nl != 16) begin errors++; $display("FAIL line_count f%0d: got %0d expected 16", fr, nl); end
      checks++; if (lmin != 16 || lmax != 16) begin errors++; $display("FAIL line_len f%0d: got %0d..%0d expected 16", fr, lmin, lmax); end
      checks++; if (front != 3 || back != 3) begin errors++; $display("FAIL front_back f%0d: got %0d/%0d expected 3/3", fr, front, back); end
      checks++; if (zv != 0) begin errors++; $display("FAIL blank_zero f%0d: got %0d nonzero samples expected 0", fr, zv); end
      bad = 0;
      for (int n = 0; n < 16; n++) if (line_first[n] !== rep(n) || !line_const[n]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL line_data f%0d: got %0d bad lines expected 0", fr, bad); end
      measure_low(100, low);
      checks++; if (low != 10) begin errors++; $display("FAIL vblank_len f%0d: got %0d expected 10", fr, low); end
    end
    enable = 1'b0;
  endtask

  task automatic test_frame_inc();
    bit ok; int fhi, nl, lmin, lmax, front, back, zv, low, bad;
    apply_reset();
    cfg(4, 2, 1, 3, 1);
    enable = 1'b1;
    for (int f = 0; f < 20; f++) begin
      measure_frame(200, ok, fhi, nl, lmin, lmax, front, back, zv);
      checks++;
      if (!ok || nl != 2 || line_first[0] !== rep(f) || line_first[1] !== rep(f) || !line_const[0] || !line_const[1]) begin
        errors++; $display("FAIL frame_data f%0d: got %h lines=%0d expected %h", f, line_first[0], nl, rep(f));
      end
    end
    // Minimal frames with zero blanking; these also carry the counter to wrap
    cfg(1, 2, 0, 0, 1);
    measure_frame(200, ok, fhi, nl, lmin, lmax, front, back, zv);
    checks++; if (!ok || fhi != 9) begin errors++; $display("FAIL hblank0_fval_high: got %0d expected 9", fhi); end
    checks++; if (nl != 2 || lmax != 1) begin errors++; $display("FAIL hblank0_lines: got %0d lines len %0d expected 2 len 1", nl, lmax); end
    checks++; if (line_first[0] !== rep(20)) begin errors++; $display("FAIL frame_data f20: got %h expected %h", line_first[0], rep(20)); end
    measure_low(50, low);
    checks++; if (low != 1) begin errors++; $display("FAIL vblank0_len: got %0d expected 1", low); end
    bad = 0;
    for (int f = 21; f < 1023; f++) begin
      measure_frame(100, ok, fhi, nl, lmin, lmax, front, back, zv);
      if (!ok || line_first[0] !== rep(f)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL frame_seq: got %0d bad frames expected 0", bad); end
    measure_frame(100, ok, fhi, nl, lmin, lmax, front, back, zv);
    checks++; if (line_first[0] !== rep(1023)) begin errors++; $display("FAIL frame_1023: got %h expected %h", line_first[0], rep(1023)); end
    measure_frame(100, ok, fhi, nl, lmin, lmax, front, back, zv);
    checks++; if (line_first[0] !== '0) begin errors++; $display("FAIL frame_wrap: got %h expected 0", line_first[0]); end
    enable = 1'b0;
  endtask

  task automatic test_pix_inc();
    bit ok; int fhi, nl, lmin, lmax, front, back, zv;
    apply_reset();
    cfg(4, 2, 2, 2, 2);
    enable = 1'b1;
    measure_frame(200, ok, fhi, nl, lmin, lmax, front, back, zv);
    checks++; if (col_data[0] !== PIX_COL0) begin errors++; $display("FAIL pix_col0: got %h expected %h", col_data[0], PIX_COL0); end
    checks++; if (col_data[3] !== PIX_COL3) begin errors++; $display("FAIL pix_col3: got %h expected %h", col_data[3], PIX_COL3); end
    checks++; if (!ok || nl != 2 || zv != 0) begin errors++; $display("FAIL pix_frame: got lines=%0d zv=%0d expected 2/0", nl, zv); end
    enable = 1'b0;
  endtask

  task automatic test_zero_pattern();
    bit ok; int fhi, nl, lmin, lmax, front, back, zv;
    apply_reset();
    cfg(4, 2, 1, 1, 3);
    enable = 1'b1;
    measure_frame(200, ok, fhi, nl, lmin, lmax, front, back, zv);
    checks++;
    if (!ok || nl != 2 || line_first[0] !== '0 || line_first[1] !== '0 || !line_const[0] || !line_const[1]) begin
      errors++; $display("FAIL zero_pattern: got %h lines=%0d expected 0 lines=2", line_first[0], nl);
    end
    enable = 1'b0;
  endtask

  task automatic test_zero_dims();
    int bad;
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      cfg(k == 0 ? 0 : 16, k == 0 ? 16 : 0, 4, 10, 0);
      enable = 1'b1;
      bad = 0;
      repeat (40) begin
        @(negedge clk);
        if (fval !== 1'b0 || lval !== 1'b0 || pix !== '0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL zero_dim%0d_idle: got %0d active samples expected 0", k, bad); end
    end
    cfg(16, 16, 4, 10, 0);
    bad = 0;
    while (fval !== 1'b1 && bad < 10) begin @(negedge clk); bad++; end
    checks++; if (fval !== 1'b1) begin errors++; $display("FAIL dims_restart: got fval %b expected 1", fval); end
    enable = 1'b0;
  endtask

  task automatic test_enable_drop();
    bit ok; int fhi, nl, lmin, lmax, front, back, zv, act;
    apply_reset();
    cfg(16, 16, 4, 10, 0);
    enable = 1'b1;
    fork
      measure_frame(2000, ok, fhi, nl, lmin, lmax, front, back, zv);
      begin : drop
        int rises;
        bit p;
        rises = 0; p = 1'b0;
        for (int c = 0; c < 2000; c++) begin
          @(negedge clk);
          if (lval === 1'b1 && !p) rises++;
          p = (lval === 1'b1);
          if (rises == 6) begin enable = 1'b0; width = 32'd8; break; end
        end
      end
    join
    checks++; if (!ok || fhi != 322 || nl != 16) begin errors++; $display("FAIL drop_frame: got fhi=%0d lines=%0d expected 322/16", fhi, nl); end
    checks++; if (lmin != 16 || lmax != 16) begin errors++; $display("FAIL drop_len: got %0d..%0d expected 16", lmin, lmax); end
    act = 0;
    repeat (300) begin @(negedge clk); if (fval !== 1'b0) act++; end
    checks++; if (act != 0) begin errors++; $display("FAIL drop_idle: got %0d fval samples expected 0", act); end
  endtask

  task automatic test_reset_clk_en();
    bit ok; int fhi, nl, lmin, lmax, front, back, zv, low, rises, c;
    bit p;
    apply_reset();
    cfg(16, 16, 4, 10, 0);
    enable = 1'b1;
    rises = 0; p = 1'b0; c = 0;
    while (rises < 3 && c < 2000) begin
      @(negedge clk); c++;
      if (lval === 1'b1 && !p) rises++;
      p = (lval === 1'b1);
    end
    repeat (5) @(negedge clk);
    checks++; if (lval !== 1'b1) begin errors++; $display("FAIL pre_reset_lval: got %b expected 1", lval); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (fval !== 1'b0 || lval !== 1'b0) begin errors++; $display("FAIL async_reset_ctl: got %b%b expected 00", fval, lval); end
    checks++; if (pix !== '0) begin errors++; $display("FAIL async_reset_pix: got %h expected 0", pix); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    toggle_en = 1'b1;
    measure_frame(4000, ok, fhi, nl, lmin, lmax, front, back, zv);
    checks++; if (!ok || fhi != 644) begin errors++; $display("FAIL clken_fval_high: got %0d expected 644", fhi); end
    checks++; if (nl != 16 || lmin != 32 || lmax != 32) begin errors++; $display("FAIL clken_lines: got %0d lines len %0d..%0d expected 16/32", nl, lmin, lmax); end
    checks++; if (front != 6 || back != 6) begin errors++; $display("FAIL clken_front_back: got %0d/%0d expected 6/6", front, back); end
    measure_low(200, low);
    checks++; if (low != 20) begin errors++; $display("FAIL clken_vblank: got %0d expected 20", low); end
    toggle_en = 1'b0;
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_line_inc();
    test_frame_inc();
    test_pix_inc();
    test_zero_pattern();
    test_zero_dims();
    test_enable_drop();
    test_reset_clk_en();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
